apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
- APB completer stage directly downstream of apb_master; consumes psel/penable/paddr/pwrite/pwdata and returns prdata/pready.
- Holds NUM_REGS read/write byte registers and inserts a programmable number of wait states per transfer.
- Flags out-of-range addresses with pslverr_o.
- Exports all register contents as a flat bus for downstream logic.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data and register width.
- NUM_REGS, 16, number of registers; valid addresses are 0..NUM_REGS-1. Range 1..2^ADDR_W.
- WAIT_CYCLES, 2, access-phase cycles with pready_o low before completion. Range 0..15.

Ports:
- pclk  input  1  clock; all logic on rising edge.
- preset  input  1  reset; asynchronous, active-high.
- psel_i  input  1  APB select from master.
- penable_i  input  1  APB enable (access phase).
- paddr_i  input  ADDR_W  register index.
- pwrite_i  input  1  1=write, 0=read.
- pwdata_i  input  DATA_W  write data.
- prdata_o  output  DATA_W  read data; valid only while pready_o=1 on a read.
- pready_o  output  1  transfer completion.
- pslverr_o  output  1  error; valid only while pready_o=1.
- regs_o  output  NUM_REGS*DATA_W  register contents; reg i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (preset=1, asynchronous):
  - state=IDLE, wait counter=0.
  - All registers = 0.
  - pready_o=0, pslverr_o=0, prdata_o=0, regs_o=0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - psel_i=1 at a rising edge → load counter with WAIT_CYCLES; next state ACCESS.
  - Applies to a setup cycle (penable_i=0) and, tolerantly, to penable_i=1.
  - Otherwise remain in IDLE.
- ACCESS:
  - pready_o = (counter==0) && psel_i && penable_i. Decoded combinationally from registered state/counter and the qualifying inputs.
  - psel_i && penable_i && counter!=0 → counter decrements each edge.
  - Completion edge (pready_o=1):
    - Write with paddr_i < NUM_REGS: register[paddr_i] ← pwdata_i.
    - Next state IDLE.
  - psel_i=0 in ACCESS (master abort) → next state IDLE; no register update; pready_o stays 0.
- Latency (setup cycle = T0, first access cycle = T1):
  - WAIT_CYCLES=0: pready_o=1 in T1; zero-wait transfer, 2 cycles total.
  - WAIT_CYCLES=N: pready_o=1 in access cycle N+1; N+2 cycles total.
- prdata_o:
  - Read, pready_o=1, paddr_i in range: register[paddr_i], combinational from storage.
  - All other cycles: 0.
- pslverr_o = pready_o && (paddr_i >= NUM_REGS).
  - Write to an out-of-range address is discarded.
  - Read from an out-of-range address returns prdata_o=0.
- Back-to-back transfers:
  - After the completion edge the FSM is in IDLE.
  - Master's next setup cycle (psel_i=1, penable_i=0) reloads the counter. No dead cycle required.
- Read-after-write to the same register on the next transfer returns the new value.
- regs_o is registered storage; it updates one edge after the write completion.
- Address comparison is unsigned at full ADDR_W. No aliasing or wrap-around; upper bits are not truncated.
- Reset mid-transfer: immediate IDLE and cleared registers. A write in flight is lost; pready_o drops asynchronously.
- pready_o is never asserted while psel_i=0.

Decomposition:
- Package apb_pkg holds:
  - state encoding constants ST_IDLE, ST_ACCESS;
  - default APB_ADDR_W=8 and APB_DATA_W=8;
  - counter width WAIT_W=4.
- Sub-module apb_slave_regs: register storage with reset.
  - Inputs: write enable, write index, write data.
  - Outputs: flat contents bus.
  - Top-level apb_regfile_slave contains the FSM, counter, decode and response muxing.

Test Plan:
1. Reset asserted 3 cycles, then released; no APB activity → pready_o=0, pslverr_o=0, prdata_o=0, regs_o all 0 throughout.
2. WAIT_CYCLES=2; write 0xA5 to addr 3 → pready_o low for 2 access cycles, high in the 3rd with pslverr_o=0. regs_o[31:24]=0xA5 one edge later. Then read addr 3 → prdata_o=0xA5 in its completion cycle.
3. WAIT_CYCLES=0; back-to-back write 0x11 to addr 0, read addr 0, with no idle cycle between → each transfer completes in 2 cycles; read returns 0x11.
4. Write 0x5A to addr 16 (NUM_REGS=16), then read addr 200 → both complete with pready_o=1 and pslverr_o=1. Read returns 0x00; regs_o unchanged.
5. Master drops psel_i in the 1st access cycle of a write of 0xFF to addr 1 (WAIT_CYCLES=2) → no pready_o, register 1 stays 0. The next normal read of addr 1 returns 0x00.
6. Assert preset during the 2nd wait cycle of a write of 0x33 to addr 2 → pready_o falls immediately, register 2=0. After release, a fresh read of addr 2 returns 0x00 with the normal latency.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared constants and types for the APB register-file completer.
// State encoding, default bus widths and the wait-counter width live here.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  localparam int WAIT_W     = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/apb_slave_regs.sv
// Byte register storage for the APB completer, cleared by asynchronous reset.
// Contents are exported as one flat bus; register i sits at [i*DATA_W +: DATA_W].
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int ADDR_W   = APB_ADDR_W,
  parameter int DATA_W   = APB_DATA_W,
  parameter int NUM_REGS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [NUM_REGS*DATA_W-1:0] contents
);

  // Index decode by comparison keeps the full address width; the caller only
  // raises wr_en for in-range indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contents <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == ADDR_W'(i)) begin
          contents[i*DATA_W +: DATA_W] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer with NUM_REGS byte registers and WAIT_CYCLES wait states per transfer.
// Out-of-range addresses complete with pslverr_o and never touch storage.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic [ADDR_W-1:0]          paddr_i,
  input  logic                       pwrite_i,
  input  logic [DATA_W-1:0]          pwdata_i,
  output logic [DATA_W-1:0]          prdata_o,
  output logic                       pready_o,
  output logic                       pslverr_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_W'(WAIT_CYCLES);
  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   NUM_REGS_LIM = (ADDR_W+1)'(NUM_REGS);

  state_t                     state;
  state_t                     state_next;
  logic [WAIT_W-1:0]          count;
  logic [WAIT_W-1:0]          count_next;
  logic                       pready;
  logic                       in_range;
  logic                       wr_en;
  logic [DATA_W-1:0]          rd_sel;
  logic [NUM_REGS*DATA_W-1:0] contents;

  assign in_range = ({1'b0, paddr_i} < NUM_REGS_LIM);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Any select in IDLE starts a transfer, even if penable is already high.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      ST_IDLE: begin
        if (psel_i) begin
          state_next = ST_ACCESS;
          count_next = WAIT_LOAD;
        end
      end
      ST_ACCESS: begin
        if (!psel_i || pready) begin
          state_next = ST_IDLE;
        end else if (penable_i && (count != '0)) begin
          count_next = count - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  always_comb begin
    pready = 1'b0;
    if ((state == ST_ACCESS) && (count == '0) && psel_i && penable_i) begin
      pready = 1'b1;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (paddr_i == ADDR_W'(i)) begin
        rd_sel = contents[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_en     = pready && pwrite_i && in_range;
  assign pready_o  = pready;
  assign pslverr_o = pready && !in_range;
  assign prdata_o  = (pready && !pwrite_i && in_range) ? rd_sel : '0;
  assign regs_o    = contents;

  apb_slave_regs #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regs (
    .clk      (pclk),
    .rst      (preset),
    .wr_en    (wr_en),
    .wr_idx   (paddr_i),
    .wr_data  (pwdata_i),
    .contents (contents)
  );

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: two instances (2 and 0 wait states) share one APB bus,
// checked every cycle against a transfer-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_apb_regfile_slave;

  logic         pclk = 1'b0;
  logic         preset;
  logic         psel, penable, pwrite;
  logic [7:0]   paddr, pwdata;
  int           sel;
  logic         psel_a, psel_b;
  logic [7:0]   prdata_a, prdata_b;
  logic         pready_a, pready_b, pslverr_a, pslverr_b;
  logic [127:0] regs_a, regs_b;

  int errors = 0;
  int checks = 0;

  assign psel_a = psel && (sel == 0);
  assign psel_b = psel && (sel == 1);

  apb_regfile_slave #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(16), .WAIT_CYCLES(2)) dut_a (
    .pclk(pclk), .preset(preset), .psel_i(psel_a), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata_a), .pready_o(pready_a), .pslverr_o(pslverr_a), .regs_o(regs_a)
  );

  apb_regfile_slave #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(16), .WAIT_CYCLES(0)) dut_b (
    .pclk(pclk), .preset(preset), .psel_i(psel_b), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata_b), .pready_o(pready_b), .pslverr_o(pslverr_b), .regs_o(regs_b)
  );

  always #5 pclk = ~pclk;

  // Model: register contents and the access-cycle index of the ongoing transfer
  logic [7:0] mem [2][16];
  int         acc [2];

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic psel_of(input int k);
    return (k == 0) ? psel_a : psel_b;
  endfunction

  function automatic logic exp_ready(input int k);
    return (acc[k] != 0) && psel_of(k) && penable && (acc[k] == wait_of(k) + 1);
  endfunction

  function automatic logic [127:0] exp_regs(input int k);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = mem[k][i];
    return v;
  endfunction

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int k = 0; k < 2; k++) begin
        acc[k] = 0;
        for (int i = 0; i < 16; i++) mem[k][i] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (acc[k] == 0) begin
          acc[k] = psel_of(k) ? 1 : 0;
        end else if (!psel_of(k)) begin
          acc[k] = 0;
        end else if (exp_ready(k)) begin
          if (pwrite && (paddr < 8'd16)) mem[k][paddr[3:0]] = pwdata;
          acc[k] = 0;
        end else if (penable) begin
          acc[k] = acc[k] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    for (int k = 0; k < 2; k++) begin
      logic       r, e;
      logic [7:0] d;
      r = exp_ready(k);
      e = r && (paddr >= 8'd16);
      d = (r && !pwrite && (paddr < 8'd16)) ? mem[k][paddr[3:0]] : 8'h00;
      checkOutput($sformatf("pready%0d", k), 128'(k == 0 ? pready_a : pready_b), 128'(r));
      checkOutput($sformatf("pslverr%0d", k), 128'(k == 0 ? pslverr_a : pslverr_b), 128'(e));
      checkOutput($sformatf("prdata%0d", k), 128'(k == 0 ? prdata_a : prdata_b), 128'(d));
      checkOutput($sformatf("regs%0d", k), (k == 0) ? regs_a : regs_b, exp_regs(k));
    end
  end

  // One complete transfer; must be called #1 after a rising edge
  task automatic applyStimulus(input int k, input logic wr, input logic [7:0] addr,
                               input logic [7:0] data, output logic [7:0] rd,
                               output logic err, output int cyc);
    logic done;
    done = 1'b0;
    rd   = 8'h00;
    err  = 1'b0;
    cyc  = 0;
    sel = k; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if ((k == 0) ? pready_a : pready_b) begin
        done = 1'b1;
        rd   = (k == 0) ? prdata_a : prdata_b;
        err  = (k == 0) ? pslverr_a : pslverr_b;
      end
      @(posedge pclk); #1;
    end
    checkOutput("complete", 128'(done), 128'(1'b1));
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [7:0]   rd;
  logic         err;
  int           cyc;
  logic [127:0] snap;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; sel = 0;

    $display("[TB] reset and idle");
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("t1_regs_a", regs_a, 128'h0);
    checkOutput("t1_ready_a", 128'(pready_a), 128'h0);

    $display("[TB] two wait states: write then read addr 3");
    applyStimulus(0, 1'b1, 8'd3, 8'hA5, rd, err, cyc);
    checkOutput("t2_wr_cyc", 128'(cyc), 128'd3);
    checkOutput("t2_wr_err", 128'(err), 128'h0);
    checkOutput("t2_regs", 128'(regs_a[31:24]), 128'hA5);
    applyStimulus(0, 1'b0, 8'd3, 8'h00, rd, err, cyc);
    checkOutput("t2_rd_data", 128'(rd), 128'hA5);
    checkOutput("t2_rd_cyc", 128'(cyc), 128'd3);

    $display("[TB] zero wait states back to back");
    applyStimulus(1, 1'b1, 8'd0, 8'h11, rd, err, cyc);
    checkOutput("t3_wr_cyc", 128'(cyc), 128'd1);
    applyStimulus(1, 1'b0, 8'd0, 8'h00, rd, err, cyc);
    checkOutput("t3_rd_data", 128'(rd), 128'h11);
    checkOutput("t3_rd_cyc", 128'(cyc), 128'd1);

    $display("[TB] out of range addresses");
    snap = regs_b;
    applyStimulus(1, 1'b1, 8'd16, 8'h5A, rd, err, cyc);
    checkOutput("t4_wr_err", 128'(err), 128'h1);
    checkOutput("t4_regs", regs_b, snap);
    applyStimulus(1, 1'b0, 8'd200, 8'h00, rd, err, cyc);
    checkOutput("t4_rd_err", 128'(err), 128'h1);
    checkOutput("t4_rd_data", 128'(rd), 128'h00);

    $display("[TB] last valid register");
    applyStimulus(0, 1'b1, 8'd15, 8'h3C, rd, err, cyc);
    checkOutput("t4b_wr_err", 128'(err), 128'h0);
    applyStimulus(0, 1'b0, 8'd15, 8'h00, rd, err, cyc);
    checkOutput("t4b_rd_data", 128'(rd), 128'h3C);
    checkOutput("t4b_regs", 128'(regs_a[127:120]), 128'h3C);

    $display("[TB] master abort");
    sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd1; pwdata = 8'hFF;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    checkOutput("t5_ready", 128'(pready_a), 128'h0);
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("t5_regs", 128'(regs_a[15:8]), 128'h00);
    applyStimulus(0, 1'b0, 8'd1, 8'h00, rd, err, cyc);
    checkOutput("t5_rd_data", 128'(rd), 128'h00);

    $display("[TB] reset mid transfer");
    sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd2; pwdata = 8'h33;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #3;
    preset = 1'b1;
    #1;
    checkOutput("t6_ready", 128'(pready_a), 128'h0);
    checkOutput("t6_regs_a", regs_a, 128'h0);
    checkOutput("t6_regs_b", regs_b, 128'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;
    applyStimulus(0, 1'b0, 8'd2, 8'h00, rd, err, cyc);
    checkOutput("t6_rd_data", 128'(rd), 128'h00);
    checkOutput("t6_rd_cyc", 128'(cyc), 128'd3);
    applyStimulus(0, 1'b0, 8'd3, 8'h00, rd, err, cyc);
    checkOutput("t6_rd3_data", 128'(rd), 128'h00);

    repeat (2) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
